// File: rtl/add_arb_pkg.sv
// Shared constants for the add_arbiter slice: FSM state encoding, default sizes and Id width.
package add_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_RES  = 2'd2;

    // Id needs at least one bit even when only two requesters exist.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/add_arb_pick.sv
// Combinational winner selection: searches req_i starting at ptr_i+1 (mod NREQ).
module add_arb_pick
    import add_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = ID_W_DEF
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    int unsigned j;

    // Walk from the farthest candidate to the nearest so the nearest asserted one wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            j = (32'(ptr_i) + k) % NREQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Shared-adder arbiter: IDLE captures one requester's operands, CAP adds, RES retires.
// Define ADD_ARB_RR_EN for round-robin arbitration; default build is fixed priority.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF,
    localparam int unsigned IW  = id_width(NREQ)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] Req,
    input  logic [NREQ*W-1:0] A,
    input  logic [NREQ*W-1:0] B,
    output logic [NREQ-1:0] Gnt,
    output logic            Busy,
    output logic [W-1:0]    Sum,
    output logic            Overflow,
    output logic            Valid,
    output logic [IW-1:0]   Id
);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   id_q, id_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      add_res;

`ifdef ADD_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    // Pointer pinned at NREQ-1 makes the search start at 0: lowest index wins.
    assign ptr = IW'(NREQ - 1);
`endif

    add_arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i (Req),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                a_sel = A[i*W +: W];
                b_sel = B[i*W +: W];
            end
        end
    end

    assign add_res = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        id_d    = id_q;
`ifdef ADD_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    state_d = ST_CAP;
                    gnt_d   = pick_gnt;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    idx_d   = pick_idx;
`ifdef ADD_ARB_RR_EN
                    ptr_d   = pick_idx;
`endif
                end
            end
            ST_CAP: begin
                state_d        = ST_RES;
                {ovf_d, sum_d} = add_res;
                id_d           = idx_q;
                valid_d        = 1'b1;
            end
            ST_RES: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

`ifdef ADD_ARB_RR_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ptr_q <= IW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign Gnt      = gnt_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Sum      = sum_q;
    assign Overflow = ovf_q;
    assign Valid    = valid_q;
    assign Id       = id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter; expected results are queued at stimulus time.
module tb_add_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] sum;
        logic       ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a   = '0;
    logic [NREQ*W-1:0] b   = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [W-1:0]      sum;
    logic              ovf;
    logic              valid;
    logic [1:0]        id;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    add_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Req      (req),
        .A        (a),
        .B        (b),
        .Gnt      (gnt),
        .Busy     (busy),
        .Sum      (sum),
        .Overflow (ovf),
        .Valid    (valid),
        .Id       (id)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int i, input int s, input int o);
        exp_t e;
        e.id  = 2'(i);
        e.sum = 4'(s);
        e.ovf = 1'(o);
        return e;
    endfunction

    // Each Valid pops and checks the oldest queued expectation.
    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got id=%0d sum=%0h ovf=%0b, required no Valid",
                         id, sum, ovf);
            end else begin
                mon_e = sb.pop_front();
                if ({id, sum, ovf} !== {mon_e.id, mon_e.sum, mon_e.ovf}) begin
                    errors++;
                    $display("FAIL result got id=%0d sum=%0h ovf=%0b, required id=%0d sum=%0h ovf=%0b",
                             id, sum, ovf, mon_e.id, mon_e.sum, mon_e.ovf);
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [3:0] av, input logic [3:0] bv);
        a[i*W +: W] = av;
        b[i*W +: W] = bv;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt, valid, busy, sum, ovf, id} !== '0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b valid=%b busy=%b sum=%h ovf=%b id=%0d, required all 0",
                     gnt, valid, busy, sum, ovf, id);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b gnt=%b, required 0 and 0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        set_op(0, 4'h3, 4'h4);
        req = 4'b0001;
        sb.push_back(mk(0, 7, 0));
        @(negedge clk);
        req = '0;
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b busy=%b valid=%b, required 0001 1 0", gnt, busy, valid);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_gnt_drop got gnt=%b, required 0000", gnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b valid=%b, required 0 0", busy, valid);
        end
    endtask

    task automatic test_overflow();
        set_op(2, 4'hF, 4'h1);
        req = 4'b0100;
        sb.push_back(mk(2, 0, 1));
        @(negedge clk);
        req = '0;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL overflow_gnt got gnt=%b, required 0100", gnt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || sum !== 4'h0 || ovf !== 1'b1 || id !== 2'd2) begin
            errors++;
            $display("FAIL overflow_hold got valid=%b sum=%h ovf=%b id=%0d, required 0 0 1 2",
                     valid, sum, ovf, id);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'(i + 2));
`ifdef ADD_ARB_RR_EN
        req = 4'b1111;
        for (int k = 0; k < 5; k++) sb.push_back(mk(k % 4, 2 * (k % 4) + 3, 0));
`else
        req = 4'b1010;
        for (int k = 0; k < 5; k++) sb.push_back(mk(1, 5, 0));
`endif
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp_v = ((n % 3) == 2) && (n <= 14);
            checks++;
            if (valid !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid_spacing cycle %0d got valid=%b, required %b", n, valid, exp_v);
            end
`ifndef ADD_ARB_RR_EN
            checks++;
            if (gnt[3] !== 1'b0) begin
                errors++;
                $display("FAIL fixed_starve cycle %0d got gnt=%b, required bit3=0", n, gnt);
            end
`endif
            if (n == 13) req = '0;
        end
    endtask

    task automatic test_reset_in_cap();
        do_reset();
        set_op(1, 4'h5, 4'h5);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cap_reached got gnt=%b busy=%b, required 0010 1", gnt, busy);
        end
        rst = 1'b1;
        req = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || sum !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_cap got busy=%b gnt=%b sum=%h valid=%b, required 0 0000 0 0",
                     busy, gnt, sum, valid);
        end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sum !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got sum=%h busy=%b, required 0 0", sum, busy);
        end
        set_op(1, 4'h5, 4'h0);
        req = 4'b0010;
        sb.push_back(mk(1, 5, 0));
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_operand_change();
        set_op(0, 4'h2, 4'h2);
        req = 4'b0001;
        sb.push_back(mk(0, 4, 0));
        @(negedge clk);
        set_op(0, 4'h9, 4'h2);
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sum !== 4'h4 || id !== 2'd0) begin
            errors++;
            $display("FAIL operand_change got sum=%h id=%0d, required 4 0", sum, id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_reset_in_cap();
        test_operand_change();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_results got %0d outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 4, SHALL set operand and sum width in bits.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Req  input  NREQ  SHALL carry one request bit per requester; bit i = requester i.
REQ-006 A  input  NREQ*W  SHALL carry packed operand A; slice [i*W +: W] belongs to requester i.
REQ-007 B  input  NREQ*W  SHALL carry packed operand B, packed as A.
REQ-008 Gnt  output  NREQ  SHALL be a one-hot, one-cycle pulse marking whose operands were captured.
REQ-009 Busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-010 Sum  output  W  SHALL hold the low W bits of the last completed addition.
REQ-011 Overflow  output  1  SHALL hold the carry-out of the last completed addition.
REQ-012 Valid  output  1  SHALL pulse for one cycle when Sum/Overflow/Id are updated.
REQ-013 Id  output  clog2(NREQ)  SHALL give the requester index owning the current Sum.

Function
REQ-014 FSM SHALL have states IDLE, CAP, RES; IDLE->CAP when Req!=0, CAP->RES always, RES->IDLE always.
REQ-015 In IDLE with Req!=0, the rising edge SHALL capture the winner's A, B slices and index, and set Gnt to one-hot(winner).
REQ-016 In IDLE with Req==0, state, Gnt, Sum, Overflow, Id SHALL hold; Gnt and Valid stay 0.
REQ-017 On the CAP->RES edge, {Overflow,Sum} SHALL load the unsigned (W+1)-bit sum of the captured operands, Id the captured index, Valid 1, Gnt 0.
REQ-018 On the RES->IDLE edge Valid SHALL return to 0; Sum, Overflow, Id SHALL hold until the next Valid.
REQ-019 Latency SHALL be: capture edge e0, Gnt high e0..e1, Valid high e1..e2, earliest next capture at e3 (one op per 3 cycles).
REQ-020 Req and operands SHALL be sampled only in IDLE; changes during CAP/RES have no effect.
REQ-021 A requester still asserting Req in IDLE after its Valid SHALL be treated as a new request.
REQ-022 Operands SHALL be sampled from registers only; a change on A/B after capture SHALL not alter the result.
REQ-023 Overflow SHALL be pure unsigned carry: 4'hF+4'h1 gives Sum 0, Overflow 1.

Reset
REQ-024 Rst high SHALL immediately force state IDLE, Gnt 0, Valid 0, Busy 0, Sum 0, Overflow 0, Id 0, captured operands 0.
REQ-025 Rst asserted during CAP or RES SHALL discard the in-flight operation without emitting Valid.
REQ-026 Round-robin pointer SHALL reset to NREQ-1 so requester 0 has first priority after reset.

Configuration
REQ-027 With ADD_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 modulo NREQ; pointer loads the winner on each capture.
REQ-028 Without ADD_ARB_RR_EN, arbitration SHALL be fixed priority, lowest asserted index wins, and no pointer register is built.

Structure
REQ-029 Package add_arb_pkg SHALL hold the state encoding (IDLE, CAP, RES), default NREQ and W, and the Id width constant.
REQ-030 Winner selection SHALL be a combinational sub-module add_arb_pick (inputs Req, pointer; output one-hot grant and index).
REQ-031 The adder datapath SHALL be inside add_arbiter; no further sub-modules.

Verification
REQ-032 Single request: Req=0001, A0=3, B0=4 -> Gnt=0001 one cycle after capture edge, then Valid=1, Sum=7, Overflow=0, Id=0.
REQ-033 Overflow: Req=0100, A2=F, B2=1 -> Valid with Sum=0, Overflow=1, Id=2; Sum holds 0 after Valid drops.
REQ-034 Contention with ADD_ARB_RR_EN, Req=1111 held -> Id sequence 0,1,2,3,0 with Valid spaced 3 cycles.
REQ-035 Contention without ADD_ARB_RR_EN, Req=1010 held -> Id 1 on every result; requester 3 never granted.
REQ-036 Rst pulsed during CAP (Req=0010, A1=5, B1=5) -> no Valid, Sum=0, state IDLE; after release a new capture yields Sum=A, Overflow=0.
REQ-037 Operand change after capture: A0=2,B0=2 captured, A0 changed to 9 in CAP -> Sum=4.
